keypad_encoder: RTL and testbench

Writer side of the timer's digit-load interface. Converts ten raw, bouncing keypad buttons (digits 0–9) into clean BCD digits on `data`, each qualified by a one-cycle active-low `loadn` strobe. The timer shifts these digits into its minutes/seconds registers. The block sits between the front-panel keypad pins and `timer_nivel2`, and its outputs drive the timer's `data`/load inputs directly.

---
 rtl/keypad_encoder_pkg.sv | 25 ++
 rtl/keypad_encoder_key_sync.sv | 26 ++
 rtl/keypad_encoder.sv | 133 +++++++++++++
 tb/tb_keypad_encoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/keypad_encoder_pkg.sv
// keypad_pkg: shared state type, sizes and the one-hot to BCD encoder used by
// the keypad digit encoder.
package keypad_pkg;

    localparam int KEY_COUNT = 10;
    localparam int BCD_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_HOLD     = 2'd3
    } kp_state_t;

    // Only ever called with a one-hot vector, so the result stays within 0-9.
    function automatic logic [BCD_W-1:0] encode_onehot(input logic [KEY_COUNT-1:0] v);
        logic [BCD_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (v[i]) idx = BCD_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_encoder_key_sync.sv
// key_sync: two-flop synchronizer for the raw keypad levels, cleared by the
// synchronous active-low clearn.
module key_sync
    import keypad_pkg::*;
#(
    parameter int WIDTH = KEY_COUNT
) (
    input  logic             clk,
    input  logic             clearn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!clearn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: debounces ten keypad buttons into BCD digits with a one-cycle
// active-low loadn strobe. Define KEYPAD_AUTOREPEAT_EN to repeat held digits.
//
// state       | meaning
// ST_IDLE     | waiting for a single synchronized key, entry not inhibited
// ST_DEBOUNCE | captured key must stay stable for DEBOUNCE_CYCLES samples
// ST_EMIT     | one-cycle loadn strobe with the encoded digit on data
// ST_HOLD     | waiting for all keys released for DEBOUNCE_CYCLES samples
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic                 clk,
    input  logic                 clearn,
    input  logic [KEY_COUNT-1:0] keys,
    input  logic                 inhibit,
    output logic [BCD_W-1:0]     data,
    output logic                 loadn,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("keypad_encoder: DEBOUNCE_CYCLES and REPEAT_CYCLES must be at least 2");
    end

    logic [KEY_COUNT-1:0] ks;
    logic [KEY_COUNT-1:0] kcap, kcap_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [BCD_W-1:0]     data_nxt;
    kp_state_t            state, state_nxt;

    key_sync #(.WIDTH(KEY_COUNT)) u_sync (
        .clk    (clk),
        .clearn (clearn),
        .d      (keys),
        .q      (ks)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep, rep_nxt;

    always_ff @(posedge clk) begin
        if (!clearn) rep <= '0;
        else         rep <= rep_nxt;
    end
`endif

    always_ff @(posedge clk) begin
        if (!clearn) begin
            state <= ST_IDLE;
            kcap  <= '0;
            cnt   <= '0;
            data  <= '0;
        end else begin
            state <= state_nxt;
            kcap  <= kcap_nxt;
            cnt   <= cnt_nxt;
            data  <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        kcap_nxt  = kcap;
        cnt_nxt   = cnt;
        data_nxt  = data;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_nxt   = '0;
`endif
        case (state)
            ST_IDLE: begin
                if ($onehot(ks) && !inhibit) begin
                    kcap_nxt  = ks;
                    cnt_nxt   = '0;
                    state_nxt = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                // Inhibit discards the pending key through HOLD so it cannot
                // be emitted once inhibit drops while the key is still down.
                if (ks != kcap) begin
                    state_nxt = ST_IDLE;
                end else if (inhibit) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_HOLD;
                end else if (cnt == DB_LAST) begin
                    data_nxt  = encode_onehot(kcap);
                    state_nxt = ST_EMIT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_EMIT: begin
                cnt_nxt   = '0;
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (ks != '0) begin
                    cnt_nxt = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (ks == kcap && !inhibit) begin
                        if (rep == REP_LAST) begin
                            data_nxt  = encode_onehot(kcap);
                            state_nxt = ST_EMIT;
                        end else begin
                            rep_nxt = rep + 1'b1;
                        end
                    end
`endif
                end else if (cnt == DB_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        loadn = 1'b1;
        busy  = (state != ST_IDLE);
        if (state == ST_EMIT && !inhibit) loadn = 1'b0;
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: scoreboard bench; expected strobes (digit and cycle) are
// queued when keys are driven and matched when loadn goes low.
module tb_keypad_encoder;

    localparam int DC = 4;
    localparam int RC = 16;

    typedef struct {
        int digit;
        int at;
    } exp_t;

    logic       clk     = 1'b0;
    logic       clearn  = 1'b0;
    logic       inhibit = 1'b0;
    logic [9:0] keys    = '0;
    logic [3:0] data;
    logic       loadn;
    logic       busy;

    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    keypad_encoder #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_CYCLES   (RC)
    ) dut (
        .clk     (clk),
        .clearn  (clearn),
        .keys    (keys),
        .inhibit (inhibit),
        .data    (data),
        .loadn   (loadn),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Key driven at a negedge with cyc=c: strobe is visible at the negedge with cyc=c+3+DC.
    task automatic push(input int digit, input int at);
        exp_t e;
        e.digit = digit;
        e.at    = at;
        exp_q.push_back(e);
    endtask

    task automatic press(input int digit, input int hold, input int rel, input int n_strobes);
        keys        = '0;
        keys[digit] = 1'b1;
        for (int k = 0; k < n_strobes; k++) push(digit, cyc + 3 + DC + k * (RC + 1));
        tick(hold);
        keys = '0;
        tick(rel);
        chk("idle_after_release", busy, 0);
    endtask

    always @(negedge clk) begin
        if (loadn === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("strobe_expected", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_data", data, mon_e.digit);
                chk("strobe_cycle", cyc, mon_e.at);
            end
        end
    end

    initial begin
        int seq[4];
        seq = '{2, 1, 7, 9};

        // Reset held with key 5 down; key stays down after release.
        keys    = '0;
        keys[5] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_data", data, 0);
            chk("rst_loadn", loadn, 1);
            chk("rst_busy", busy, 0);
        end
        clearn = 1'b1;
        push(5, cyc + 3 + DC);
        tick(1);
        chk("post_rst_loadn", loadn, 1);
        tick(19);
        keys = '0;
        tick(20);
        chk("rst_key_release_idle", busy, 0);

        // Clean press of 7, busy checked mid-hold.
        keys    = '0;
        keys[7] = 1'b1;
        push(7, cyc + 3 + DC);
        tick(10);
        chk("hold_busy", busy, 1);
        tick(10);
        keys = '0;
        tick(20);
        chk("clean_release_idle", busy, 0);

        // Bounce on 3: toggles every 2 cycles, last rise stays high.
        for (int i = 0; i < 4; i++) begin
            keys[3] = (i % 2 == 0);
            tick(2);
        end
        keys[3] = 1'b1;
        push(3, cyc + 3 + DC);
        tick(20);
        keys = '0;
        tick(20);
        chk("bounce_release_idle", busy, 0);

        // Two keys together are never accepted.
        keys[1] = 1'b1;
        keys[2] = 1'b1;
        tick(20);
        chk("multi_busy", busy, 0);
        keys = '0;
        tick(10);

        // Inhibit during debounce of 9 discards it; only a fresh press emits.
        keys[9] = 1'b1;
        tick(4);
        inhibit = 1'b1;
        tick(6);
        inhibit = 1'b0;
        tick(8);
        chk("inhibit_held_busy", busy, 1);
        keys = '0;
        tick(20);
        chk("inhibit_release_idle", busy, 0);
        press(9, 20, 20, 1);

        // Digit sequence.
        for (int i = 0; i < 4; i++) press(seq[i], 20, 20, 1);

        // Reset during debounce aborts the pending strobe and clears data.
        keys[6] = 1'b1;
        tick(5);
        clearn = 1'b0;
        keys   = '0;
        tick(2);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", data, 0);
        clearn = 1'b1;
        tick(20);

        // Long hold of 4: repeats only when auto-repeat is built in.
`ifdef KEYPAD_AUTOREPEAT_EN
        press(4, 60, 20, 4);
`else
        press(4, 60, 20, 1);
`endif

        tick(5);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
